// File: rtl/apb_pkg.sv
`default_nettype none
//==============================================================================
// apb_pkg : shared FSM encoding, decode constants and request record
// Revision: 1.0
//==============================================================================
package apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_RESP   = 3'd4
  } apb_state_t;

  localparam int c_NUM_SLAVES      = 4;
  localparam int c_SEL_LSB         = 12;
  localparam int c_SEL_MSB         = 13;
  localparam int c_DEC_LSB         = 14;
  localparam int c_DEFAULT_TIMEOUT = 255;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  prot;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_req_t;

  localparam int c_REQ_W = $bits(apb_req_t);

  function automatic logic [c_NUM_SLAVES-1:0] f_onehot(input logic [c_SEL_MSB-c_SEL_LSB:0] idx);
    logic [c_NUM_SLAVES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_req_bridge_if.sv
`default_nettype none
//==============================================================================
// apb_req_bridge_if : request/response handshakes and APB-side signals
// Revision: 1.0
//==============================================================================
interface apb_req_bridge_if
  import apb_pkg::*;
;
  logic                    req_valid;
  logic                    req_ready;
  logic [31:0]             req_addr;
  logic                    req_write;
  logic [2:0]              req_prot;
  logic [31:0]             req_wdata;
  logic [3:0]              req_strb;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;

  logic [31:0]             m_paddr;
  logic                    m_pwrite;
  logic [2:0]              m_pprot;
  logic [31:0]             m_pwdata;
  logic [3:0]              m_pstrb;
  logic [c_NUM_SLAVES-1:0] m_psel;
  logic                    m_penable;
  logic                    m_pready;
  logic [31:0]             m_prdata;
  logic                    m_pslverr;

  // Environment side: issues requests, consumes responses, models the APB completer.
  modport master (
    output req_valid, req_addr, req_write, req_prot, req_wdata, req_strb, rsp_ready,
           m_penable, m_pready, m_prdata, m_pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_paddr, m_pwrite, m_pprot, m_pwdata, m_pstrb, m_psel
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_prot, req_wdata, req_strb, rsp_ready,
           m_penable, m_pready, m_prdata, m_pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_paddr, m_pwrite, m_pprot, m_pwdata, m_pstrb, m_psel
  );

endinterface
`default_nettype wire

// File: rtl/apb_req_fifo.sv
`default_nettype none
//==============================================================================
// apb_req_fifo : synchronous FIFO with full/empty/count, async active-high reset
// Revision: 1.0
//==============================================================================
module apb_req_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int c_AW  = $clog2(DEPTH),
  localparam int c_CW  = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic      [c_CW-1:0]  o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == c_CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_req_bridge.sv
`default_nettype none
//==============================================================================
// apb_req_bridge : buffered request-to-APB bridge with decode, timeout, in-order responses
// Revision: 1.0
//==============================================================================
module apb_req_bridge
  import apb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = c_DEFAULT_TIMEOUT
) (
  input  wire logic         pclk,
  input  wire logic         preset,
  apb_req_bridge_if.slave   bus,
  output logic              busy
);

  localparam int         c_CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  apb_req_t                w_push_req;
  apb_req_t                w_head;
  logic [c_REQ_W-1:0]      w_head_bits;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [c_CW-1:0]         w_count;

  apb_state_t              r_state;
  logic                    r_run;
  logic [7:0]              r_tmo;
  logic [31:0]             r_paddr;
  logic                    r_pwrite;
  logic [2:0]              r_pprot;
  logic [31:0]             r_pwdata;
  logic [3:0]              r_pstrb;
  logic [c_NUM_SLAVES-1:0] r_psel;
  logic                    r_rsp_valid;
  logic [31:0]             r_rsp_rdata;
  logic                    r_rsp_err;

  assign w_push_req = '{addr:  bus.req_addr,  write: bus.req_write, prot: bus.req_prot,
                        wdata: bus.req_wdata, strb:  bus.req_strb};
  assign w_head     = apb_req_t'(w_head_bits);

  // r_run keeps req_ready low while reset is held, without touching req_valid.
  assign bus.req_ready = r_run & ~w_full;
  assign w_push        = bus.req_valid & bus.req_ready;
  assign w_pop         = (r_state == ST_IDLE) & ~w_empty;

  apb_req_fifo #(
    .WIDTH (c_REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst     (preset),
    .i_push  (w_push),
    .i_wdata (w_push_req),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= ST_IDLE;
      r_run       <= 1'b0;
      r_tmo       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pprot     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_psel      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (|w_head.addr[31:c_DEC_LSB]) begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_paddr  <= w_head.addr;
              r_pwrite <= w_head.write;
              r_pprot  <= w_head.prot;
              r_pwdata <= w_head.write ? w_head.wdata : 32'd0;
              r_pstrb  <= w_head.write ? w_head.strb  : 4'd0;
              r_psel   <= f_onehot(w_head.addr[c_SEL_MSB:c_SEL_LSB]);
              r_state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_tmo   <= '0;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Completion wins over timeout when both land on the same edge.
          if (bus.m_penable && bus.m_pready) begin
            r_rsp_rdata <= (!r_pwrite && !bus.m_pslverr) ? bus.m_prdata : 32'd0;
            r_rsp_err   <= bus.m_pslverr;
            r_psel      <= '0;
            r_state     <= ST_GAP;
          end else if (r_tmo == c_TMO_LAST) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_psel      <= '0;
            r_state     <= ST_GAP;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        ST_GAP: begin
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_paddr   = r_paddr;
  assign bus.m_pwrite  = r_pwrite;
  assign bus.m_pprot   = r_pprot;
  assign bus.m_pwdata  = r_pwdata;
  assign bus.m_pstrb   = r_pstrb;
  assign bus.m_psel    = r_psel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign busy          = (r_state != ST_IDLE) | (w_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_apb_req_bridge.sv
`default_nettype none
//==============================================================================
// tb_apb_req_bridge : scoreboard bench for apb_req_bridge (TIMEOUT = 8)
// Revision: 1.0
//==============================================================================
module tb_apb_req_bridge;
  import apb_pkg::*;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  logic busy;

  apb_req_bridge_if bif ();

  apb_req_bridge #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bif),
    .busy   (busy)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  typedef struct {
    logic [3:0]  psel;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  prot;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          hi;
  } apb_exp_t;

  rsp_exp_t rsp_q[$];
  apb_exp_t apb_q[$];

  int          slv_wait  = 0;
  bit          slv_hang  = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err   = 1'b0;

  // APB completer model plus per-transfer field / duration checks.
  initial begin
    int       sel_cnt;
    bit       have;
    apb_exp_t cur;
    sel_cnt = 0;
    have    = 0;
    bif.m_penable = 1'b0;
    bif.m_pready  = 1'b0;
    bif.m_prdata  = 32'h0;
    bif.m_pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        sel_cnt = 0;
        have    = 0;
        bif.m_penable = 1'b0;
        bif.m_pready  = 1'b0;
        continue;
      end
      if (bif.m_psel != 4'b0) begin
        sel_cnt++;
        if (sel_cnt == 1) begin
          if (apb_q.size() == 0) begin
            check_eq("apb_unexpected_psel", bif.m_psel, 4'b0);
            have = 0;
          end else begin
            cur  = apb_q.pop_front();
            have = 1;
          end
        end
        if (have)
          check_eq("apb_fields", {bif.m_psel, bif.m_paddr, bif.m_pwrite, bif.m_pprot, bif.m_pwdata, bif.m_pstrb},
                   {cur.psel, cur.addr, cur.wr, cur.prot, cur.wdata, cur.strb});
        bif.m_penable = (sel_cnt >= 2);
        bif.m_pready  = (sel_cnt >= 2) && !slv_hang && ((sel_cnt - 2) >= slv_wait);
        bif.m_prdata  = slv_rdata;
        bif.m_pslverr = slv_err;
      end else begin
        if (have) check_eq("psel_high_cycles", sel_cnt, cur.hi);
        sel_cnt = 0;
        have    = 0;
        bif.m_penable = 1'b0;
        bif.m_pready  = 1'b0;
        bif.m_pslverr = 1'b0;
      end
    end
  end

  // Response scoreboard: every handshake must match the oldest accepted request.
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge pclk);
      if (!preset && bif.rsp_valid && bif.rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", bif.rsp_valid, 1'b0);
        end else begin
          e = rsp_q.pop_front();
          check_eq("rsp_rdata", bif.rsp_rdata, e.rdata);
          check_eq("rsp_err", bif.rsp_err, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge pclk);
    #2;
  endtask

  // Caller must be at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [31:0] addr, input logic wr, input logic [2:0] prot,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hi);
    int       k;
    apb_exp_t a;
    logic [3:0] one;
    one = 4'b0001;
    bif.req_valid = 1'b1;
    bif.req_addr  = addr;
    bif.req_write = wr;
    bif.req_prot  = prot;
    bif.req_wdata = wdata;
    bif.req_strb  = strb;
    for (k = 0; k < 300; k++) begin
      @(negedge pclk);
      if (bif.req_ready) break;
    end
    if (k == 300) begin
      check_eq("req_accept_timeout", bif.req_ready, 1'b1);
    end else begin
      if (addr[31:14] == 18'd0) begin
        a.psel  = one << addr[13:12];
        a.addr  = addr;
        a.wr    = wr;
        a.prot  = prot;
        a.wdata = wr ? wdata : 32'd0;
        a.strb  = wr ? strb : 4'd0;
        a.hi    = hi;
        apb_q.push_back(a);
      end
      rsp_q.push_back('{rdata: exp_rdata, err: exp_err});
    end
    @(posedge pclk);
    #2;
    bif.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge pclk);
      if (!busy && rsp_q.size() == 0 && apb_q.size() == 0) break;
    end
    if (k == 500) check_eq("idle_timeout", busy, 1'b0);
    sync();
  endtask

  initial begin
    int          k;
    bit          seen;
    logic [31:0] a;
    logic        w;
    bif.req_valid = 1'b0;
    bif.req_addr  = '0;
    bif.req_write = 1'b0;
    bif.req_prot  = '0;
    bif.req_wdata = '0;
    bif.req_strb  = '0;
    bif.rsp_ready = 1'b1;

    #2;
    check_eq("reset_outputs",
             {bif.req_ready, bif.rsp_valid, bif.rsp_rdata, bif.rsp_err, bif.m_psel, bif.m_paddr,
              bif.m_pwrite, bif.m_pprot, bif.m_pwdata, bif.m_pstrb, busy}, 128'd0);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check_eq("ready_after_reset", bif.req_ready, 1'b1);
    check_eq("busy_after_reset", busy, 1'b0);
    sync();

    // Write to slave 2 with one wait state; read data must not leak into a write response.
    slv_wait = 1; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
    send(32'h0000_2004, 1'b1, 3'b010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3);
    wait_idle();

    // Read from slave 3; write fields in the request must be zeroed on the bus.
    slv_wait = 0; slv_rdata = 32'h1234_5678;
    send(32'h0000_3000, 1'b0, 3'b001, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 1'b0, 2);
    wait_idle();

    // Slave error on a read returns zero data.
    slv_wait = 2; slv_rdata = 32'h55AA_55AA; slv_err = 1'b1;
    send(32'h0000_1010, 1'b0, 3'b000, 32'h0, 4'h0, 32'h0, 1'b1, 4);
    wait_idle();
    slv_err = 1'b0;

    // Decode error: no APB activity, response within 3 cycles.
    send(32'h0001_0000, 1'b0, 3'b000, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    for (k = 1; k <= 4; k++) begin
      @(negedge pclk);
      if (bif.rsp_valid) break;
    end
    check_eq("dec_err_latency_le3", (k <= 3), 1'b1);
    wait_idle();

    // Timeout: 1 SETUP + 8 ACCESS cycles with psel high, then abort.
    slv_hang = 1;
    send(32'h0000_0000, 1'b0, 3'b000, 32'h0, 4'h0, 32'h0, 1'b1, 9);
    wait_idle();
    slv_hang = 0;

    // Back-to-back burst with responses stalled: FIFO fills, responses stay ordered.
    bif.rsp_ready = 1'b0;
    slv_wait = 0; slv_rdata = 32'h600D_0001;
    send(32'h0000_0000, 1'b0, 3'b000, 32'h0,         4'h0, 32'h600D_0001, 1'b0, 2);
    send(32'h0000_1000, 1'b1, 3'b011, 32'h1111_2222, 4'h3, 32'h0,         1'b0, 2);
    send(32'h4000_0000, 1'b0, 3'b000, 32'h0,         4'h0, 32'h0,         1'b1, 0);
    send(32'h0000_2008, 1'b0, 3'b100, 32'h0,         4'h0, 32'h600D_0001, 1'b0, 2);
    send(32'h0000_3FFC, 1'b1, 3'b000, 32'h3333_4444, 4'hC, 32'h0,         1'b0, 2);
    @(negedge pclk);
    check_eq("ready_low_when_full", bif.req_ready, 1'b0);
    check_eq("busy_when_full", busy, 1'b1);
    sync();
    bif.rsp_ready = 1'b1;
    wait_idle();

    // Mixed traffic across all regions.
    for (int i = 0; i < 6; i++) begin
      a = {18'd0, 2'($urandom), 10'($urandom), 2'b00};
      w = 1'($urandom);
      slv_wait  = int'($urandom_range(0, 2));
      slv_rdata = $urandom;
      send(a, w, 3'($urandom), $urandom, 4'($urandom), w ? 32'h0 : slv_rdata, 1'b0, 2 + slv_wait);
      wait_idle();
    end

    // Reset during ACCESS with one request in flight and one buffered.
    slv_hang = 1;
    send(32'h0000_2000, 1'b0, 3'b000, 32'h0,         4'h0, 32'h0, 1'b0, 9);
    send(32'h0000_3000, 1'b1, 3'b000, 32'h7777_8888, 4'hF, 32'h0, 1'b0, 2);
    for (k = 0; k < 50; k++) begin
      @(negedge pclk);
      if (bif.m_psel != 4'b0) break;
    end
    check_eq("psel_before_reset", bif.m_psel, 4'b0100);
    repeat (2) @(negedge pclk);
    #2;
    preset = 1'b1;
    #1;
    check_eq("async_reset_outputs",
             {bif.req_ready, bif.rsp_valid, bif.rsp_rdata, bif.rsp_err, bif.m_psel, bif.m_paddr,
              bif.m_pwrite, bif.m_pprot, bif.m_pwdata, bif.m_pstrb, busy}, 128'd0);
    apb_q.delete();
    rsp_q.delete();
    slv_hang = 0;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (bif.rsp_valid || bif.m_psel != 4'b0) seen = 1;
    end
    check_eq("no_activity_after_reset", seen, 1'b0);
    check_eq("ready_after_mid_reset", bif.req_ready, 1'b1);
    check_eq("idle_after_mid_reset", busy, 1'b0);
    sync();

    // Recovery transfer after reset.
    slv_wait = 0; slv_rdata = 32'h0BAD_F00D;
    send(32'h0000_1004, 1'b0, 3'b000, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 2);
    wait_idle();

    check_eq("rsp_queue_drained", rsp_q.size(), 0);
    check_eq("apb_queue_drained", apb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
